// File: rtl/program_ram_pkg.sv
// Shared definitions for the program_ram block: controller state encoding
// and the default address/data widths.
package program_ram_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage : program_ram_pkg

// File: rtl/program_ram_ram_array.sv
// Byte-wide storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset so a loaded image survives rst_n.
module ram_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // NOTE: storage arrays get no reset branch; resetting them would turn the
    // array into a huge flop bank and would also destroy the loaded image.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Reads see the old word until the write edge.
    assign rdata = r_mem[raddr];

endmodule : ram_array

// File: rtl/program_ram.sv
// Program/data RAM with a host-side image loader that holds the CPU stalled
// until the image is in, plus a running byte checksum of the load.
module program_ram
    import program_ram_pkg::*;
#(
    parameter int ADDR_W = program_ram_pkg::ADDR_W,
    parameter int DATA_W = program_ram_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_data,
    input  logic              ram_rw,
    output logic [DATA_W-1:0] ram_out,
    output logic              cpu_hold,
    input  logic              load_start,
    input  logic              run_req,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              load_done,
    output logic [DATA_W-1:0] load_sum,
    output logic [ADDR_W-1:0] load_ptr
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] r_len;
    logic [DATA_W-1:0] r_sum;
    logic              r_done;
    logic              r_hold;
    logic              r_ready;

    logic              w_accept;
    logic              w_last;
    logic              w_clear;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    // A length of 0 means full depth: the last index is then 2^ADDR_W-1.
    assign w_accept = (r_state == ST_LOAD) && load_valid;
    assign w_last   = w_accept && (r_ptr == (r_len - ADDR_W'(1)));
    assign w_clear  = load_start && (r_state != ST_LOAD);

    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (load_start) begin
                    w_next = ST_LOAD;
                end else if (run_req) begin
                    w_next = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (w_last) begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (load_start) begin
                    w_next = ST_LOAD;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_len   <= '0;
            r_sum   <= '0;
            r_done  <= 1'b0;
            r_hold  <= 1'b1;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_last;
            r_hold  <= (w_next != ST_RUN);
            r_ready <= (w_next == ST_LOAD);
            if (w_clear) begin
                r_ptr <= '0;
                r_sum <= '0;
                r_len <= load_len;
            end else if (w_accept) begin
                r_ptr <= r_ptr + ADDR_W'(1);
                r_sum <= r_sum + load_data;
            end
        end
    end

    // Loader owns the write port in LOAD; the CPU only writes in RUN.
    assign w_we    = w_accept || ((r_state == ST_RUN) && ram_rw);
    assign w_waddr = w_accept ? r_ptr     : ram_addr;
    assign w_wdata = w_accept ? load_data : ram_data;

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram_array (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (w_wdata),
        .raddr (ram_addr),
        .rdata (ram_out)
    );

    assign cpu_hold   = r_hold;
    assign load_ready = r_ready;
    assign load_done  = r_done;
    assign load_sum   = r_sum;
    assign load_ptr   = r_ptr;

endmodule : program_ram

// File: tb/tb_program_ram.sv
// Directed self-checking bench for program_ram: loads, CPU write gating,
// request priority and reset in the middle of a load.
module tb_program_ram;

    logic       clk;
    logic       rst_n;
    logic [7:0] ram_addr;
    logic [7:0] ram_data;
    logic       ram_rw;
    logic [7:0] ram_out;
    logic       cpu_hold;
    logic       load_start;
    logic       run_req;
    logic [7:0] load_len;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       load_done;
    logic [7:0] load_sum;
    logic [7:0] load_ptr;

    int n_checks;
    int n_errors;

    program_ram dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .ram_rw     (ram_rw),
        .ram_out    (ram_out),
        .cpu_hold   (cpu_hold),
        .load_start (load_start),
        .run_req    (run_req),
        .load_len   (load_len),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .load_done  (load_done),
        .load_sum   (load_sum),
        .load_ptr   (load_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        ram_addr = addr;
        #1;
        check(tag, 32'(ram_out), 32'(exp));
    endtask

    function automatic logic [7:0] img(input int i);
        return 8'((i * 7 + 3) & 8'hFF);
    endfunction

    logic [7:0] bytes4 [4];
    logic [7:0] exp_sum;
    int         n_done;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        ram_addr   = '0;
        ram_data   = '0;
        ram_rw     = 1'b0;
        load_start = 1'b0;
        run_req    = 1'b0;
        load_len   = '0;
        load_valid = 1'b0;
        load_data  = '0;
        bytes4[0]  = 8'h11;
        bytes4[1]  = 8'h22;
        bytes4[2]  = 8'h33;
        bytes4[3]  = 8'h44;

        // Reset state
        #12;
        check("rst_hold",  32'(cpu_hold),   32'd1);
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_done",  32'(load_done),  32'd0);
        check("rst_ptr",   32'(load_ptr),   32'd0);
        check("rst_sum",   32'(load_sum),   32'd0);
        rst_n = 1'b1;
        tick();

        // Load 4 bytes then read back
        load_start = 1'b1;
        load_len   = 8'd4;
        tick();
        load_start = 1'b0;
        check("l4_ready", 32'(load_ready), 32'd1);
        check("l4_hold",  32'(cpu_hold),   32'd1);
        for (int i = 0; i < 4; i++) begin
            load_valid = 1'b1;
            load_data  = bytes4[i];
            tick();
            if (i == 2) check("l4_done_early", 32'(load_done), 32'd0);
        end
        load_valid = 1'b0;
        check("l4_done",  32'(load_done),  32'd1);
        check("l4_hold0", 32'(cpu_hold),   32'd0);
        check("l4_rdy0",  32'(load_ready), 32'd0);
        check("l4_sum",   32'(load_sum),   32'hAA);
        check("l4_ptr",   32'(load_ptr),   32'd4);
        read_check("l4_rd2", 8'd2, 8'h33);
        tick();
        check("l4_done_pulse", 32'(load_done), 32'd0);

        // load_start from RUN with a CPU write in the same cycle
        load_start = 1'b1;
        load_len   = 8'd0;
        ram_rw     = 1'b1;
        ram_addr   = 8'h10;
        ram_data   = 8'h77;
        tick();
        load_start = 1'b0;
        ram_rw     = 1'b0;
        check("rs_hold",  32'(cpu_hold),   32'd1);
        check("rs_ready", 32'(load_ready), 32'd1);
        check("rs_sum",   32'(load_sum),   32'd0);
        check("rs_ptr",   32'(load_ptr),   32'd0);
        read_check("rs_cpu_wr", 8'h10, 8'h77);

        // Gapped full-depth load, requests during LOAD ignored
        exp_sum = '0;
        for (int i = 0; i < 256; i++) exp_sum = exp_sum + img(i);
        n_done = 0;
        for (int j = 0; j <= 510; j++) begin
            load_valid = (j % 2 == 0);
            load_data  = (j % 2 == 0) ? img(j / 2) : 8'hFF;
            load_start = (j == 11);
            run_req    = (j == 11);
            tick();
            if (load_done) n_done++;
            if (j == 11) begin
                check("fd_ignore_ready", 32'(load_ready), 32'd1);
                check("fd_ignore_ptr",   32'(load_ptr),   32'd6);
            end
            if (j == 509) check("fd_ptr255", 32'(load_ptr), 32'd255);
        end
        load_valid = 1'b0;
        load_start = 1'b0;
        run_req    = 1'b0;
        check("fd_done",    32'(load_done), 32'd1);
        check("fd_ndone",   32'(n_done),    32'd1);
        check("fd_ptrwrap", 32'(load_ptr),  32'd0);
        check("fd_hold0",   32'(cpu_hold),  32'd0);
        check("fd_sum",     32'(load_sum),  32'(exp_sum));
        read_check("fd_mem255", 8'd255, img(255));
        read_check("fd_mem16",  8'h10,  img(16));
        tick();
        check("fd_done_pulse", 32'(load_done), 32'd0);

        // CPU write in RUN: old value until the edge, new value after
        ram_rw   = 1'b1;
        ram_data = 8'h5A;
        read_check("run_wr_old", 8'h10, img(16));
        tick();
        ram_rw = 1'b0;
        read_check("run_wr_new", 8'h10, 8'h5A);

        // Reset in the middle of an 8-byte load
        load_start = 1'b1;
        load_len   = 8'd8;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = 8'hC1 + 8'(i);
            tick();
        end
        load_valid = 1'b0;
        check("ml_ptr3", 32'(load_ptr), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("ml_hold",  32'(cpu_hold),   32'd1);
        check("ml_ready", 32'(load_ready), 32'd0);
        check("ml_ptr",   32'(load_ptr),   32'd0);
        check("ml_sum",   32'(load_sum),   32'd0);
        rst_n = 1'b1;
        read_check("ml_mem0", 8'd0, 8'hC1);
        read_check("ml_mem1", 8'd1, 8'hC2);
        read_check("ml_mem2", 8'd2, 8'hC3);
        read_check("ml_mem3", 8'd3, img(3));
        tick();

        // CPU write in IDLE is dropped
        ram_rw   = 1'b1;
        ram_addr = 8'h10;
        ram_data = 8'hEE;
        tick();
        ram_rw = 1'b0;
        read_check("idle_wr_drop", 8'h10, 8'h5A);
        check("idle_hold", 32'(cpu_hold), 32'd1);

        // run_req from IDLE
        run_req = 1'b1;
        tick();
        run_req = 1'b0;
        check("idle_run_hold", 32'(cpu_hold), 32'd0);

        // Back to IDLE, then load_start and run_req together: LOAD wins
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        load_start = 1'b1;
        run_req    = 1'b1;
        load_len   = 8'd1;
        tick();
        load_start = 1'b0;
        run_req    = 1'b0;
        check("both_ready", 32'(load_ready), 32'd1);
        check("both_hold",  32'(cpu_hold),   32'd1);
        load_valid = 1'b1;
        load_data  = 8'h3C;
        tick();
        load_valid = 1'b0;
        check("l1_done", 32'(load_done), 32'd1);
        check("l1_sum",  32'(load_sum),  32'h3C);
        check("l1_hold", 32'(cpu_hold),  32'd0);
        read_check("l1_mem0", 8'd0, 8'h3C);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_program_ram
